// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-controller states, error codes and reset vector.
package mips_pkg;
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_ERR} state_t;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC mux with jr > jump > branch > sequential priority.
module pc_next_sel (
  input  logic [31:0] i_pc_plus4,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_offset,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);
  always_comb begin
    o_next_pc = i_jr ? i_jr_target :
                i_jump ? {i_pc_plus4[31:28], i_jump_index, 2'b00} :
                i_branch_taken ? i_pc_plus4 + (i_branch_offset << 2) : i_pc_plus4;
    o_misaligned = i_jr && (i_jr_target[1:0] != 2'b00);
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and fetch/wait/exec sequencer with timeout and jr alignment errors.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          WAIT_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        err,
  output logic [1:0]  err_code
);
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_bad_jr;

  pc_next_sel u_sel (
    .i_pc_plus4     (pc_plus4),
    .i_branch_taken (branch_taken),
    .i_branch_offset(branch_offset),
    .i_jump         (jump),
    .i_jump_index   (jump_index),
    .i_jr           (jr),
    .i_jr_target    (jr_target),
    .o_next_pc      (w_next_pc),
    .o_misaligned   (w_misaligned)
  );

  always_comb begin
    w_timeout = (r_state == S_WAIT) && !imem_ack && (r_cnt == 8'(WAIT_TIMEOUT - 1));
    w_bad_jr  = (r_state == S_EXEC) && w_misaligned;
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: w_state_nxt = en ? S_WAIT : S_FETCH;
      S_WAIT:  w_state_nxt = imem_ack ? S_EXEC : w_timeout ? S_ERR : S_WAIT;
      S_EXEC:  w_state_nxt = w_misaligned ? S_ERR : S_FETCH;
      S_ERR:   w_state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_VECTOR;
      r_cnt      <= 8'd0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_WAIT && !imem_ack) ? r_cnt + 8'd1 : 8'd0;
      if (r_state == S_EXEC && !w_misaligned) r_pc <= w_next_pc;
      if (w_timeout) {r_err, r_err_code} <= {1'b1, ERR_TIMEOUT};
      if (w_bad_jr) {r_err, r_err_code} <= {1'b1, ERR_MISALIGN};
    end
  end

  // Request is gated by reset so an in-flight fetch drops without waiting for a clock edge.
  assign imem_req    = !reset && ((r_state == S_WAIT) || (r_state == S_FETCH && en));
  assign instr_valid = (r_state == S_EXEC);
  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign err         = r_err;
  assign err_code    = r_err_code;
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter register and fetch sequencer for the MIPS core. It closes the loop around the sequential-increment path. It holds the PC, issues an instruction-memory request, and waits for the acknowledge. It then samples the control-flow decision for the current instruction and registers the next PC: sequential, branch, jump or jr. It sits between the control unit / branch comparator and the instruction memory port.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
WAIT_TIMEOUT, 16, maximum cycles in S_WAIT before a fetch timeout error; legal range 1..255.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  fetch enable; 0 holds the core in S_FETCH with no request.
imem_req  output  1  instruction-memory request.
imem_addr  output  32  fetch address; always equals pc.
imem_ack  input  1  memory acknowledge; instruction data is valid in the same cycle.
instr_valid  output  1  one-cycle pulse; the current instruction executes this cycle.
pc  output  32  current PC.
pc_plus4  output  32  pc + 4, combinational, modulo 2^32.
branch_taken  input  1  conditional branch resolved taken; sampled only when instr_valid=1.
branch_offset  input  32  sign-extended word offset.
jump  input  1  j/jal; sampled only when instr_valid=1.
jump_index  input  26  instruction index field.
jr  input  1  jr/jalr; sampled only when instr_valid=1.
jr_target  input  32  register-sourced target.
err  output  1  sticky error flag.
err_code  output  2  error cause: 00 none, 01 misaligned jr target, 10 fetch timeout.

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous and active-high, and may assert in any state.
- Values under reset: pc=RESET_VECTOR, state=S_FETCH, imem_req=0, instr_valid=0, err=0, err_code=00, timeout counter=0.

State machine:
- S_FETCH:
  - en=1: imem_req=1, next state S_WAIT.
  - en=0: imem_req=0, stay in S_FETCH.
- S_WAIT:
  - imem_req=1. imem_addr is held stable.
  - Counter increments each cycle.
  - imem_ack=1: next state S_EXEC, counter cleared.
  - Counter reaches WAIT_TIMEOUT with no ack: err=1, err_code=10, next state S_ERR.
- S_EXEC:
  - instr_valid=1, imem_req=0.
  - Next PC is registered at the end of this cycle, then next state S_FETCH.
  - Each instruction therefore costs at least 3 cycles.
- S_ERR:
  - imem_req=0, instr_valid=0, pc frozen.
  - Left only via reset.
- imem_ack outside S_WAIT is ignored.
- en is ignored outside S_FETCH. An in-flight fetch always completes.

Next-PC selection (S_EXEC only), priority jr > jump > branch > sequential:
- jr: next = jr_target.
  - If jr_target[1:0] != 00: pc is unchanged, err=1, err_code=01, next state S_ERR.
- jump: next = {pc_plus4[31:28], jump_index, 2'b00}.
- branch_taken: next = pc_plus4 + (branch_offset << 2), truncated to 32 bits.
- Otherwise: next = pc_plus4.

Arithmetic and boundary rules:
- All arithmetic is modulo 2^32; 32'hFFFF_FFFC sequential wraps to 0.
- Branch and jump targets are always word-aligned by construction. Only jr is checked for alignment.
- Simultaneous assertion of jr, jump and branch_taken resolves by priority. This is not an error.
- Reset during S_WAIT drops imem_req in the same cycle. The pending ack is discarded.
- Once set, err and err_code stay set until reset.

Decomposition:
- Shared package mips_pkg holds:
  - state typedef {S_FETCH, S_WAIT, S_EXEC, S_ERR}
  - error code constants ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT
  - the default RESET_VECTOR constant
- One natural combinational sub-module: pc_next_sel. It takes pc_plus4, the control inputs and the targets. It outputs the next PC and a misaligned flag.
- The FSM, PC register and timeout counter stay in pc_fetch_ctrl.

Test Plan:
1. Reset, then en=1 with ack one cycle after req, run 3 instructions -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 3 cycles.
2. At pc=0x0000_0010, branch_taken=1, branch_offset=32'hFFFF_FFFC -> next pc=0x0000_0004. Then jump=1, jump_index=26'h000_0040 -> pc=0x0000_0100.
3. jr=1, jump=1 and branch_taken=1 together, jr_target=0x0000_2000 -> pc=0x0000_2000. Then jr_target=0x0000_2002 -> err=1, err_code=01, pc holds 0x2000, imem_req stays 0.
4. pc=0xFFFF_FFFC, sequential -> pc=0x0000_0000. Also ack withheld for WAIT_TIMEOUT=16 cycles -> err_code=10 exactly at the 16th S_WAIT cycle.
5. en=0 in S_FETCH for 5 cycles -> imem_req=0, pc unchanged. Then en=1 -> request resumes at the same address.
6. reset asserted mid-S_WAIT -> imem_req drops asynchronously, pc=RESET_VECTOR. A late ack after release is ignored, and fetch restarts at RESET_VECTOR.
